// File: rtl/instr_feeder.sv
// Instruction-side responder for the pipelined MIPS CPU: serves a loaded program
// word-by-word on the fetch PC, then flushes the pipeline with NOPs and reports done.
module instr_feeder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DRAIN = 4
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic [31:0]   pc,
    input  logic          stall,
    output logic [31:0]   i_datain,
    output logic          i_valid,
    output logic          busy,
    output logic          done,
    output logic          misalign,
    output logic [15:0]   issued_cnt
);

    localparam int             DW         = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN - 1);
    localparam logic [31:0]    NOP        = 32'h0000_0000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        r_state, w_next_state;
    logic [31:0]   r_buf [DEPTH];
    logic [AW:0]   r_len, w_next_len;
    logic [DW-1:0] r_drain, w_next_drain;
    logic [31:0]   r_data, w_next_data;
    logic          r_valid, w_next_valid;
    logic          r_misalign, w_next_misalign;
    logic [15:0]   r_issued, w_next_issued;

    logic [AW-1:0] w_idx;
    logic          w_hi_zero;
    logic          w_aligned;
    logic          w_in_prog;
    logic          w_can_load;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_idx      = pc[AW+1:2];
    assign w_hi_zero  = (pc[31:AW+2] == '0);
    assign w_aligned  = (pc[1:0] == 2'b00);
    assign w_in_prog  = ({1'b0, w_idx} < r_len) && w_hi_zero;
    assign w_can_load = load_en && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Program store is deliberately not reset so a program survives rst_n.
    always_ff @(posedge clock) begin
        if (w_can_load) begin
            r_buf[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_drain    <= '0;
            r_data     <= NOP;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_issued   <= 16'd0;
        end else begin
            r_state    <= w_next_state;
            r_len      <= w_next_len;
            r_drain    <= w_next_drain;
            r_data     <= w_next_data;
            r_valid    <= w_next_valid;
            r_misalign <= w_next_misalign;
            r_issued   <= w_next_issued;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_len      = r_len;
        w_next_drain    = r_drain;
        w_next_data     = r_data;
        w_next_valid    = r_valid;
        w_next_misalign = r_misalign;
        w_next_issued   = r_issued;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_next_data  = NOP;
                w_next_valid = 1'b0;
                if (start) begin
                    w_next_state    = S_RUN;
                    w_next_len      = prog_len;
                    w_next_issued   = 16'd0;
                    w_next_misalign = 1'b0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (w_in_prog && w_aligned) begin
                        w_next_data   = r_buf[w_idx];
                        w_next_valid  = 1'b1;
                        w_next_issued = sat_inc(r_issued);
                    end else if (!w_aligned) begin
                        // A misaligned fetch is flagged but does not end the run.
                        w_next_data     = NOP;
                        w_next_valid    = 1'b0;
                        w_next_misalign = 1'b1;
                    end else begin
                        w_next_data  = NOP;
                        w_next_valid = 1'b0;
                        w_next_state = S_DRAIN;
                        w_next_drain = DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    w_next_data  = NOP;
                    w_next_valid = 1'b0;
                    if (r_drain == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_drain = r_drain - 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign i_datain   = r_data;
    assign i_valid    = r_valid;
    assign misalign   = r_misalign;
    assign issued_cnt = r_issued;
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);

endmodule
